core_branch_ctrl: RTL and testbench
===================================

# core_branch_ctrl

Branch resolution controller for the RV32I pipeline. It accepts control-transfer instructions (conditional branch, JAL, JALR) from decode and waits for forwarded register operands. It then evaluates the condition, computes the target and sequences the PC redirect, the pipeline flush and the link write-back. Prediction is static not-taken, so every taken transfer costs a redirect plus a flush window.

## Interface

- FLUSH_CYCLES, default 2: number of cycles FLUSH is held after a taken transfer; legal range 1..15, 0 is illegal.
- CLK  in  1  clock, all state on rising edge.
- NRST  in  1  reset, synchronous, active-low.
- ID_VALID  in  1  decode presents a control-transfer instruction.
- ID_READY  out  1  controller can accept; high only in IDLE.
- ID_KIND  in  2  00 cond branch, 01 JAL, 10 JALR, 11 reserved.
- ID_FUNCT3  in  3  branch funct3.
- ID_PC  in  32  instruction PC.
- ID_IMM  in  32  sign-extended immediate.
- OPS_VALID  in  1  REG_RDATA1/2 hold final forwarded values this cycle.
- REG_RDATA1  in  32  rs1 value.
- REG_RDATA2  in  32  rs2 value.
- REDIRECT_VALID  out  1  one-cycle pulse, fetch must load REDIRECT_PC.
- REDIRECT_PC  out  32  redirect target.
- FLUSH  out  1  squash younger instructions in fetch/decode.
- LINK_VALID  out  1  one-cycle pulse, write LINK_DATA to rd.
- LINK_DATA  out  32  ID_PC+4 of the JAL/JALR.
- EXC_MISALIGN  out  1  one-cycle pulse, taken target not 4-byte aligned.
- TAKEN_CNT  out  16  saturating count of successful redirects.

## Operation

- FSM states: IDLE, WAIT_OPS, RESOLVE, FLUSH.
- IDLE: ID_READY=1. A handshake occurs when ID_VALID & ID_READY at a rising edge. On handshake, latch KIND/FUNCT3/PC/IMM.
  - JAL goes to RESOLVE.
  - Cond or JALR goes to WAIT_OPS.
  - Reserved kind is accepted and dropped; state stays IDLE and no outputs change.
- WAIT_OPS: on an edge with OPS_VALID=1, latch RDATA1/2 and go to RESOLVE. Otherwise hold indefinitely. OPS_VALID is ignored in every other state.
- RESOLVE, evaluated from the latched values:
  - Condition by funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge. 010/011 are never taken.
  - JAL and JALR are always taken.
  - Target: cond/JAL = PC+IMM; JALR = (rs1+IMM) & ~1. Addition is 32-bit and wraps modulo 2^32.
  - Misaligned means taken and target[1]=1.
- Edge leaving RESOLVE, all outputs registered:
  - Taken and aligned: REDIRECT_VALID<=1, REDIRECT_PC<=target, TAKEN_CNT++ (holds at 0xFFFF).
  - Taken and misaligned: EXC_MISALIGN<=1, REDIRECT_VALID stays 0, LINK_VALID stays 0, count unchanged.
  - JAL/JALR not misaligned: LINK_VALID<=1, LINK_DATA<=PC+4.
  - Next state: FLUSH if taken (including misaligned), IDLE if not taken.
- FLUSH: FLUSH=1 for exactly FLUSH_CYCLES cycles, using an internal down-counter. Then go to IDLE. REDIRECT_VALID, LINK_VALID and EXC_MISALIGN are high only in the first FLUSH cycle.
- REDIRECT_PC and LINK_DATA hold their last value until next written.
- Reset: NRST=0 at an edge in any state, including mid-flush, forces the following:
  - State becomes IDLE.
  - All outputs become 0 except ID_READY=1.
  - TAKEN_CNT=0, all latches cleared, and any in-flight instruction is discarded.

## Timing

- Handshake at edge T.
- JAL: RESOLVE in cycle T+1; REDIRECT_VALID and FLUSH start at T+2; FLUSH ends after T+1+FLUSH_CYCLES; ID_READY=1 from T+2+FLUSH_CYCLES.
- Cond/JALR with OPS_VALID first high in cycle T+k (k>=1): RESOLVE in T+k+1, redirect in T+k+2.
- Not-taken branch: ID_READY=1 in the cycle after RESOLVE, with no FLUSH and no pulses.
- Only one instruction is in flight. ID_VALID while ID_READY=0 is ignored, and decode must hold it.

## Test plan

- BEQ, PC=0x100, IMM=0x20, rs1=rs2=5, OPS_VALID one cycle after accept -> REDIRECT_VALID pulse with REDIRECT_PC=0x120; FLUSH high 2 cycles; TAKEN_CNT=1; no LINK_VALID.
- BLT and BLTU with rs1=0xFFFFFFFF, rs2=1 -> BLT taken; BLTU not taken with no FLUSH and ID_READY back the cycle after RESOLVE. Funct3=010 -> not taken.
- JAL, PC=0x200, IMM=0xFFFFFFF8 -> redirect to 0x1F8 at T+2 with no OPS_VALID needed; LINK_DATA=0x204.
- JALR rs1=0x1001, IMM=4 -> target 0x1004. JALR rs1=0x1002, IMM=0 -> EXC_MISALIGN pulse, no redirect, no link, FLUSH still 2 cycles, count unchanged.
- OPS_VALID held low 5 cycles -> state stays WAIT_OPS, ID_READY=0, all pulses 0; resolves 2 cycles after OPS_VALID rises.
- NRST=0 during first FLUSH cycle -> next cycle FLUSH=0, TAKEN_CNT=0, ID_READY=1. Separately, preload TAKEN_CNT at 0xFFFF and take a branch -> count stays 0xFFFF.

Source files
------------

// File: rtl/core_branch_ctrl.sv
// Branch resolution controller for the RV32I pipeline: resolves cond branches, JAL and JALR,
// then sequences the PC redirect, the flush window and the link write-back (static not-taken).
module core_branch_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic        ID_VALID_i,
    output logic        ID_READY_o,
    input  logic [1:0]  ID_KIND_i,
    input  logic [2:0]  ID_FUNCT3_i,
    input  logic [31:0] ID_PC_i,
    input  logic [31:0] ID_IMM_i,
    input  logic        OPS_VALID_i,
    input  logic [31:0] REG_RDATA1_i,
    input  logic [31:0] REG_RDATA2_i,
    output logic        REDIRECT_VALID_o,
    output logic [31:0] REDIRECT_PC_o,
    output logic        FLUSH_o,
    output logic        LINK_VALID_o,
    output logic [31:0] LINK_DATA_o,
    output logic        EXC_MISALIGN_o,
    output logic [15:0] TAKEN_CNT_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_OPS, S_RESOLVE, S_FLUSH} state_e;

    localparam logic [1:0] KIND_COND  = 2'b00;
    localparam logic [1:0] KIND_JAL   = 2'b01;
    localparam logic [1:0] KIND_JALR  = 2'b10;
    localparam logic [1:0] KIND_RSVD  = 2'b11;
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  kind_q, kind_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        link_valid_q, link_valid_d;
    logic [31:0] link_data_q, link_data_d;
    logic        exc_q, exc_d;
    logic [15:0] taken_cnt_q, taken_cnt_d;

    logic        cond_taken;
    logic        is_jump;
    logic        taken;
    logic [31:0] target_sum;
    logic [31:0] target;
    logic        misaligned;

    // Branch condition from the latched operands; funct3 010/011 are never taken.
    always_comb begin
        cond_taken = 1'b0;
        case (funct3_q)
            3'b000:  cond_taken = (rs1_q == rs2_q);
            3'b001:  cond_taken = (rs1_q != rs2_q);
            3'b100:  cond_taken = ($signed(rs1_q) <  $signed(rs2_q));
            3'b101:  cond_taken = ($signed(rs1_q) >= $signed(rs2_q));
            3'b110:  cond_taken = (rs1_q <  rs2_q);
            3'b111:  cond_taken = (rs1_q >= rs2_q);
            default: cond_taken = 1'b0;
        endcase
    end

    assign is_jump    = (kind_q == KIND_JAL) || (kind_q == KIND_JALR);
    assign taken      = is_jump || ((kind_q == KIND_COND) && cond_taken);
    assign target_sum = ((kind_q == KIND_JALR) ? rs1_q : pc_q) + imm_q;
    assign target     = (kind_q == KIND_JALR) ? {target_sum[31:1], 1'b0} : target_sum;
    assign misaligned = taken && target[1];

    always_comb begin
        state_d          = state_q;
        kind_d           = kind_q;
        funct3_d         = funct3_q;
        pc_d             = pc_q;
        imm_d            = imm_q;
        rs1_d            = rs1_q;
        rs2_d            = rs2_q;
        flush_cnt_d      = flush_cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        link_valid_d     = 1'b0;
        link_data_d      = link_data_q;
        exc_d            = 1'b0;
        taken_cnt_d      = taken_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (ID_VALID_i) begin
                    kind_d   = ID_KIND_i;
                    funct3_d = ID_FUNCT3_i;
                    pc_d     = ID_PC_i;
                    imm_d    = ID_IMM_i;
                    // JAL needs no register operands; reserved kinds are swallowed here.
                    if (ID_KIND_i == KIND_JAL) begin
                        state_d = S_RESOLVE;
                    end else if (ID_KIND_i != KIND_RSVD) begin
                        state_d = S_WAIT_OPS;
                    end
                end
            end
            S_WAIT_OPS: begin
                if (OPS_VALID_i) begin
                    rs1_d   = REG_RDATA1_i;
                    rs2_d   = REG_RDATA2_i;
                    state_d = S_RESOLVE;
                end
            end
            S_RESOLVE: begin
                if (taken) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                    if (misaligned) begin
                        exc_d = 1'b1;
                    end else begin
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = target;
                        if (taken_cnt_q != 16'hFFFF) begin
                            taken_cnt_d = taken_cnt_q + 16'd1;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
                if (is_jump && !misaligned) begin
                    link_valid_d = 1'b1;
                    link_data_d  = pc_q + 32'd4;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state_q          <= S_IDLE;
            kind_q           <= 2'd0;
            funct3_q         <= 3'd0;
            pc_q             <= 32'd0;
            imm_q            <= 32'd0;
            rs1_q            <= 32'd0;
            rs2_q            <= 32'd0;
            flush_cnt_q      <= 4'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            link_valid_q     <= 1'b0;
            link_data_q      <= 32'd0;
            exc_q            <= 1'b0;
            taken_cnt_q      <= 16'd0;
        end else begin
            state_q          <= state_d;
            kind_q           <= kind_d;
            funct3_q         <= funct3_d;
            pc_q             <= pc_d;
            imm_q            <= imm_d;
            rs1_q            <= rs1_d;
            rs2_q            <= rs2_d;
            flush_cnt_q      <= flush_cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            link_valid_q     <= link_valid_d;
            link_data_q      <= link_data_d;
            exc_q            <= exc_d;
            taken_cnt_q      <= taken_cnt_d;
        end
    end

    assign ID_READY_o       = (state_q == S_IDLE);
    assign FLUSH_o          = (state_q == S_FLUSH);
    assign REDIRECT_VALID_o = redirect_valid_q;
    assign REDIRECT_PC_o    = redirect_pc_q;
    assign LINK_VALID_o     = link_valid_q;
    assign LINK_DATA_o      = link_data_q;
    assign EXC_MISALIGN_o   = exc_q;
    assign TAKEN_CNT_o      = taken_cnt_q;

endmodule

// File: tb/tb_core_branch_ctrl.sv
// Bench for core_branch_ctrl: directed scenarios plus random instructions checked against
// a timeline model derived from the resolution rules (cycle numbers relative to the accept edge).
module tb_core_branch_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        idValid = 1'b0;
    logic        idReady;
    logic [1:0]  idKind = 2'd0;
    logic [2:0]  idFunct3 = 3'd0;
    logic [31:0] idPc = 32'd0;
    logic [31:0] idImm = 32'd0;
    logic        opsValid = 1'b0;
    logic [31:0] regRdata1 = 32'd0;
    logic [31:0] regRdata2 = 32'd0;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        flush;
    logic        linkValid;
    logic [31:0] linkData;
    logic        excMisalign;
    logic [15:0] takenCnt;

    int total = 0;
    int bad = 0;

    logic [15:0] expCnt = 16'd0;
    logic [31:0] expLastRedirPc = 32'd0;
    logic [31:0] expLastLinkData = 32'd0;
    int          expReady, expFlushCnt, expFlushFirst, expRedirCnt, expRedirCycle;
    int          expLinkCnt, expLinkCycle, expExcCnt, expExcCycle;
    logic [31:0] expRedirPc, expLinkData;

    int          obsReady, obsFlushCnt, obsFlushFirst, obsRedirCnt, obsRedirCycle;
    int          obsLinkCnt, obsLinkCycle, obsExcCnt, obsExcCycle;
    logic [31:0] obsRedirPc, obsLinkData, obsRedirPcEnd, obsLinkDataEnd;
    logic [15:0] obsCnt;

    core_branch_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .CLK              (clk),
        .NRST             (nrst),
        .ID_VALID_i       (idValid),
        .ID_READY_o       (idReady),
        .ID_KIND_i        (idKind),
        .ID_FUNCT3_i      (idFunct3),
        .ID_PC_i          (idPc),
        .ID_IMM_i         (idImm),
        .OPS_VALID_i      (opsValid),
        .REG_RDATA1_i     (regRdata1),
        .REG_RDATA2_i     (regRdata2),
        .REDIRECT_VALID_o (redirectValid),
        .REDIRECT_PC_o    (redirectPc),
        .FLUSH_o          (flush),
        .LINK_VALID_o     (linkValid),
        .LINK_DATA_o      (linkData),
        .EXC_MISALIGN_o   (excMisalign),
        .TAKEN_CNT_o      (takenCnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Expected timeline for one instruction accepted at edge T, operands offered in cycle T+k.
    task automatic refModel(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] pc,
                            input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                            input int k);
        int          resolve;
        bit          taken;
        bit          mis;
        logic [31:0] target;
        expFlushCnt = 0; expFlushFirst = -1; expRedirCnt = 0; expRedirCycle = -1;
        expLinkCnt = 0; expLinkCycle = -1; expExcCnt = 0; expExcCycle = -1;
        expRedirPc = 32'd0; expLinkData = 32'd0;
        if (kind == 2'b11) begin
            expReady = 1;
            return;
        end
        resolve = (kind == 2'b01) ? 1 : k + 1;
        taken = 1'b1;
        if (kind == 2'b00) begin
            case (f3)
                3'b000:  taken = (rs1 == rs2);
                3'b001:  taken = (rs1 != rs2);
                3'b100:  taken = (int'(rs1) <  int'(rs2));
                3'b101:  taken = (int'(rs1) >= int'(rs2));
                3'b110:  taken = (rs1 <  rs2);
                3'b111:  taken = (rs1 >= rs2);
                default: taken = 1'b0;
            endcase
        end
        target = (kind == 2'b10) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
        mis = taken && ((target % 4) != 0);
        if (taken) begin
            expFlushCnt = FC;
            expFlushFirst = resolve + 1;
            expReady = resolve + 1 + FC;
            if (mis) begin
                expExcCnt = 1;
                expExcCycle = resolve + 1;
            end else begin
                expRedirCnt = 1;
                expRedirCycle = resolve + 1;
                expRedirPc = target;
                expLastRedirPc = target;
                if (expCnt != 16'hFFFF) expCnt = expCnt + 16'd1;
            end
        end else begin
            expReady = resolve + 1;
        end
        if (kind != 2'b00 && !mis) begin
            expLinkCnt = 1;
            expLinkCycle = resolve + 1;
            expLinkData = pc + 32'd4;
            expLastLinkData = pc + 32'd4;
        end
    endtask

    // Issues one instruction from idle and records what the DUT does until it is ready again.
    task automatic applyStimulus(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] pc,
                                 input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                                 input int k);
        idValid = 1'b1; idKind = kind; idFunct3 = f3; idPc = pc; idImm = imm;
        opsValid = 1'b0; regRdata1 = $urandom; regRdata2 = $urandom;
        obsReady = -1; obsFlushCnt = 0; obsFlushFirst = -1; obsRedirCnt = 0; obsRedirCycle = -1;
        obsLinkCnt = 0; obsLinkCycle = -1; obsExcCnt = 0; obsExcCycle = -1;
        obsRedirPc = 32'd0; obsLinkData = 32'd0; obsRedirPcEnd = 32'hx; obsLinkDataEnd = 32'hx;
        obsCnt = 16'hx;
        @(posedge clk);
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            if (redirectValid) begin obsRedirCnt++; obsRedirCycle = j; obsRedirPc = redirectPc; end
            if (linkValid) begin obsLinkCnt++; obsLinkCycle = j; obsLinkData = linkData; end
            if (excMisalign) begin obsExcCnt++; obsExcCycle = j; end
            if (flush) begin
                if (obsFlushCnt == 0) obsFlushFirst = j;
                obsFlushCnt++;
            end
            if (idReady) begin
                obsReady = j; obsCnt = takenCnt;
                obsRedirPcEnd = redirectPc; obsLinkDataEnd = linkData;
                break;
            end
            idValid = 1'($urandom_range(0, 1));
            idKind = 2'($urandom_range(0, 3));
            idFunct3 = 3'($urandom_range(0, 7));
            idPc = $urandom; idImm = $urandom;
            if (j < k) begin
                opsValid = 1'b0; regRdata1 = $urandom; regRdata2 = $urandom;
            end else if (j == k) begin
                opsValid = 1'b1; regRdata1 = rs1; regRdata2 = rs2;
            end else begin
                opsValid = 1'($urandom_range(0, 1)); regRdata1 = $urandom; regRdata2 = $urandom;
            end
        end
        idValid = 1'b0;
        opsValid = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({idReady, flush, redirectValid, linkValid, excMisalign} !== 5'b10000) begin
            bad++; $display("[TB] FAIL reset_flags got=%b exp=10000", {idReady, flush, redirectValid, linkValid, excMisalign});
        end
        total++;
        if ({redirectPc, linkData} !== 64'd0) begin
            bad++; $display("[TB] FAIL reset_data got=%h/%h exp=0/0", redirectPc, linkData);
        end
        total++;
        if (takenCnt !== 16'd0) begin
            bad++; $display("[TB] FAIL reset_cnt got=%h exp=0", takenCnt);
        end
        nrst = 1'b1;
        expCnt = 16'd0; expLastRedirPc = 32'd0; expLastLinkData = 32'd0;
    endtask

    task automatic test_beq();
        refModel(2'b00, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1);
        applyStimulus(2'b00, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1);
        total++;
        if (obsRedirCnt !== 1 || obsRedirCycle !== 3 || obsRedirPc !== 32'h120) begin
            bad++; $display("[TB] FAIL beq_redirect got=%0d@%0d pc=%h exp=1@3 pc=120", obsRedirCnt, obsRedirCycle, obsRedirPc);
        end
        total++;
        if (obsFlushCnt !== 2 || obsFlushFirst !== 3 || obsReady !== 5) begin
            bad++; $display("[TB] FAIL beq_flush got=%0d from %0d ready=%0d exp=2 from 3 ready=5", obsFlushCnt, obsFlushFirst, obsReady);
        end
        total++;
        if (obsLinkCnt !== 0 || obsExcCnt !== 0) begin
            bad++; $display("[TB] FAIL beq_nolink got link=%0d exc=%0d exp=0/0", obsLinkCnt, obsExcCnt);
        end
        total++;
        if (obsCnt !== 16'd1) begin
            bad++; $display("[TB] FAIL beq_cnt got=%h exp=1", obsCnt);
        end
    endtask

    task automatic test_compare();
        refModel(2'b00, 3'b100, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 2);
        applyStimulus(2'b00, 3'b100, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 2);
        total++;
        if (obsRedirCnt !== 1 || obsRedirPc !== 32'h340 || obsCnt !== expCnt) begin
            bad++; $display("[TB] FAIL blt_taken got=%0d pc=%h cnt=%h exp=1 pc=340 cnt=%h", obsRedirCnt, obsRedirPc, obsCnt, expCnt);
        end
        refModel(2'b00, 3'b110, 32'h380, 32'h40, 32'hFFFF_FFFF, 32'd1, 1);
        applyStimulus(2'b00, 3'b110, 32'h380, 32'h40, 32'hFFFF_FFFF, 32'd1, 1);
        total++;
        if (obsFlushCnt !== 0 || obsReady !== 3) begin
            bad++; $display("[TB] FAIL bltu_nottaken got flush=%0d ready=%0d exp=0/3", obsFlushCnt, obsReady);
        end
        total++;
        if (obsRedirCnt + obsLinkCnt + obsExcCnt !== 0 || obsRedirPcEnd !== 32'h340) begin
            bad++; $display("[TB] FAIL bltu_quiet got pulses=%0d pc=%h exp=0 pc=340", obsRedirCnt + obsLinkCnt + obsExcCnt, obsRedirPcEnd);
        end
        refModel(2'b00, 3'b010, 32'h3C0, 32'h40, 32'd7, 32'd7, 1);
        applyStimulus(2'b00, 3'b010, 32'h3C0, 32'h40, 32'd7, 32'd7, 1);
        total++;
        if (obsFlushCnt !== 0 || obsRedirCnt !== 0 || obsReady !== 3) begin
            bad++; $display("[TB] FAIL f3_010 got flush=%0d redir=%0d ready=%0d exp=0/0/3", obsFlushCnt, obsRedirCnt, obsReady);
        end
        refModel(2'b11, 3'b000, 32'h3D0, 32'h40, 32'd7, 32'd7, 1);
        applyStimulus(2'b11, 3'b000, 32'h3D0, 32'h40, 32'd7, 32'd7, 1);
        total++;
        if (obsReady !== 1 || obsFlushCnt + obsRedirCnt + obsLinkCnt + obsExcCnt !== 0) begin
            bad++; $display("[TB] FAIL reserved_drop got ready=%0d activity=%0d exp=1/0", obsReady, obsFlushCnt + obsRedirCnt + obsLinkCnt + obsExcCnt);
        end
    endtask

    task automatic test_jumps();
        refModel(2'b01, 3'b000, 32'h200, 32'hFFFF_FFF8, 32'd0, 32'd0, 20);
        applyStimulus(2'b01, 3'b000, 32'h200, 32'hFFFF_FFF8, 32'd0, 32'd0, 20);
        total++;
        if (obsRedirCycle !== 2 || obsRedirPc !== 32'h1F8 || obsReady !== 2 + FC) begin
            bad++; $display("[TB] FAIL jal_redirect got @%0d pc=%h ready=%0d exp=@2 pc=1f8 ready=%0d", obsRedirCycle, obsRedirPc, obsReady, 2 + FC);
        end
        total++;
        if (obsLinkCnt !== 1 || obsLinkCycle !== 2 || obsLinkData !== 32'h204) begin
            bad++; $display("[TB] FAIL jal_link got=%0d@%0d data=%h exp=1@2 data=204", obsLinkCnt, obsLinkCycle, obsLinkData);
        end
        refModel(2'b10, 3'b000, 32'h600, 32'd4, 32'h1001, 32'd0, 1);
        applyStimulus(2'b10, 3'b000, 32'h600, 32'd4, 32'h1001, 32'd0, 1);
        total++;
        if (obsRedirPc !== 32'h1004 || obsLinkData !== 32'h604 || obsCnt !== expCnt) begin
            bad++; $display("[TB] FAIL jalr_target got pc=%h link=%h cnt=%h exp=1004/604/%h", obsRedirPc, obsLinkData, obsCnt, expCnt);
        end
        refModel(2'b10, 3'b000, 32'h700, 32'd0, 32'h1002, 32'd0, 1);
        applyStimulus(2'b10, 3'b000, 32'h700, 32'd0, 32'h1002, 32'd0, 1);
        total++;
        if (obsExcCnt !== 1 || obsExcCycle !== 3 || obsRedirCnt !== 0 || obsLinkCnt !== 0) begin
            bad++; $display("[TB] FAIL jalr_misalign got exc=%0d@%0d redir=%0d link=%0d exp=1@3/0/0", obsExcCnt, obsExcCycle, obsRedirCnt, obsLinkCnt);
        end
        total++;
        if (obsFlushCnt !== 2 || obsCnt !== expCnt || obsRedirPcEnd !== 32'h1004 || obsLinkDataEnd !== 32'h604) begin
            bad++; $display("[TB] FAIL jalr_misalign_hold got flush=%0d cnt=%h pc=%h link=%h exp=2/%h/1004/604", obsFlushCnt, obsCnt, obsRedirPcEnd, obsLinkDataEnd, expCnt);
        end
    endtask

    task automatic test_wait_ops();
        refModel(2'b00, 3'b001, 32'h400, 32'h10, 32'd1, 32'd2, 6);
        applyStimulus(2'b00, 3'b001, 32'h400, 32'h10, 32'd1, 32'd2, 6);
        total++;
        if (obsRedirCycle !== 8 || obsFlushFirst !== 8 || obsReady !== 10) begin
            bad++; $display("[TB] FAIL wait_ops got redir@%0d flush@%0d ready=%0d exp=8/8/10", obsRedirCycle, obsFlushFirst, obsReady);
        end
        total++;
        if (obsRedirPc !== 32'h410 || obsRedirCnt !== 1 || obsLinkCnt !== 0) begin
            bad++; $display("[TB] FAIL wait_ops_target got pc=%h n=%0d link=%0d exp=410/1/0", obsRedirPc, obsRedirCnt, obsLinkCnt);
        end
    endtask

    task automatic test_reset_midflush();
        idValid = 1'b1; idKind = 2'b01; idFunct3 = 3'd0; idPc = 32'h500; idImm = 32'h8;
        @(posedge clk);
        @(negedge clk);
        idValid = 1'b0;
        @(negedge clk);
        total++;
        if (flush !== 1'b1 || redirectValid !== 1'b1) begin
            bad++; $display("[TB] FAIL midflush_pre got flush=%b redir=%b exp=1/1", flush, redirectValid);
        end
        nrst = 1'b0;
        @(negedge clk);
        total++;
        if ({idReady, flush, redirectValid, linkValid, excMisalign} !== 5'b10000) begin
            bad++; $display("[TB] FAIL midflush_flags got=%b exp=10000", {idReady, flush, redirectValid, linkValid, excMisalign});
        end
        total++;
        if (takenCnt !== 16'd0 || redirectPc !== 32'd0 || linkData !== 32'd0) begin
            bad++; $display("[TB] FAIL midflush_state got cnt=%h pc=%h link=%h exp=0/0/0", takenCnt, redirectPc, linkData);
        end
        nrst = 1'b1;
        expCnt = 16'd0; expLastRedirPc = 32'd0; expLastLinkData = 32'd0;
    endtask

    task automatic test_saturation();
        force dut.taken_cnt_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.taken_cnt_q;
        @(posedge clk);
        @(negedge clk);
        expCnt = 16'hFFFE;
        total++;
        if (takenCnt !== 16'hFFFE) begin
            bad++; $display("[TB] FAIL sat_preload got=%h exp=fffe", takenCnt);
        end
        for (int n = 0; n < 2; n++) begin
            refModel(2'b01, 3'b000, 32'h800, 32'h40, 32'd0, 32'd0, 1);
            applyStimulus(2'b01, 3'b000, 32'h800, 32'h40, 32'd0, 32'd0, 1);
            total++;
            if (obsCnt !== 16'hFFFF || obsRedirCnt !== 1) begin
                bad++; $display("[TB] FAIL sat_cnt[%0d] got=%h redir=%0d exp=ffff/1", n, obsCnt, obsRedirCnt);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  kind;
        logic [2:0]  f3;
        logic [31:0] pc, imm, rs1, rs2;
        int          k;
        for (int n = 0; n < 80; n++) begin
            kind = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            f3 = 3'($urandom_range(0, 7));
            pc = $urandom & 32'hFFFF_FFFC;
            imm = $urandom & 32'hFFFF_FFFE;
            rs1 = ($urandom_range(0, 3) == 0) ? 32'(int'($urandom_range(0, 8)) - 4) : $urandom;
            rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
            k = $urandom_range(1, 4);
            refModel(kind, f3, pc, imm, rs1, rs2, k);
            applyStimulus(kind, f3, pc, imm, rs1, rs2, k);
            total++;
            if (obsReady !== expReady || obsFlushCnt !== expFlushCnt || obsFlushFirst !== expFlushFirst) begin
                bad++; $display("[TB] FAIL rnd%0d_timing got ready=%0d flush=%0d@%0d exp ready=%0d flush=%0d@%0d", n, obsReady, obsFlushCnt, obsFlushFirst, expReady, expFlushCnt, expFlushFirst);
            end
            total++;
            if (obsRedirCnt !== expRedirCnt || obsRedirCycle !== expRedirCycle || obsRedirPc !== expRedirPc) begin
                bad++; $display("[TB] FAIL rnd%0d_redirect got %0d@%0d pc=%h exp %0d@%0d pc=%h", n, obsRedirCnt, obsRedirCycle, obsRedirPc, expRedirCnt, expRedirCycle, expRedirPc);
            end
            total++;
            if (obsLinkCnt !== expLinkCnt || obsLinkCycle !== expLinkCycle || obsLinkData !== expLinkData) begin
                bad++; $display("[TB] FAIL rnd%0d_link got %0d@%0d data=%h exp %0d@%0d data=%h", n, obsLinkCnt, obsLinkCycle, obsLinkData, expLinkCnt, expLinkCycle, expLinkData);
            end
            total++;
            if (obsExcCnt !== expExcCnt || obsExcCycle !== expExcCycle) begin
                bad++; $display("[TB] FAIL rnd%0d_exc got %0d@%0d exp %0d@%0d", n, obsExcCnt, obsExcCycle, expExcCnt, expExcCycle);
            end
            total++;
            if (obsCnt !== expCnt || obsRedirPcEnd !== expLastRedirPc || obsLinkDataEnd !== expLastLinkData) begin
                bad++; $display("[TB] FAIL rnd%0d_hold got cnt=%h pc=%h link=%h exp cnt=%h pc=%h link=%h", n, obsCnt, obsRedirPcEnd, obsLinkDataEnd, expCnt, expLastRedirPc, expLastLinkData);
            end
        end
    endtask

    initial begin
        test_reset();
        test_beq();
        test_compare();
        test_jumps();
        test_wait_ops();
        test_reset_midflush();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
